// File: rtl/gpio_input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : gpio_input_debounce
// Description : Per-bit 2-flop synchroniser, stability-window debouncer, rise/
//               fall pulses, sticky maskable edge-pending flags and IRQ line.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_input_debounce #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [WIDTH-1:0] gp_raw_i,
    output logic [WIDTH-1:0] gp_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    input  logic [WIDTH-1:0] edge_en_i,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] edge_pending_o,
    output logic             irq_o
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_pending;
    logic             r_irq;

    logic [WIDTH-1:0] w_differ;
    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_pending_next;

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gp_raw_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_differ = r_sync2 ^ r_level;

    // One stability counter per bit; any agreement with the accepted level restarts the window.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CNT_W-1:0] r_cnt;

        assign w_accept[i] = w_differ[i] && (r_cnt == c_CNT_LAST);

        always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
            if (!rst_sys_ni) begin
                r_cnt <= '0;
            end else if (!w_differ[i] || w_accept[i]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Setting an edge flag takes priority over a simultaneous clear.
    assign w_pending_next = (w_accept & edge_en_i) | (r_pending & ~clr_i);

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            r_level   <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_pending <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_level   <= r_level ^ w_accept;
            r_rise    <= w_accept & r_sync2;
            r_fall    <= w_accept & ~r_sync2;
            r_pending <= w_pending_next;
            r_irq     <= |w_pending_next;
        end
    end

    assign gp_o           = r_level;
    assign rise_o         = r_rise;
    assign fall_o         = r_fall;
    assign edge_pending_o = r_pending;
    assign irq_o          = r_irq;

endmodule
`default_nettype wire
